// File: rtl/mux_nto1_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types, limits and helpers for the N:1 valid/ready
//                multiplexer with direct-select and round-robin modes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Selection mode driven on the top-level mode pin
    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_t;

    // Largest supported channel count; index width follows from it
    localparam int N_MAX = 32;
    localparam int IDX_W = $clog2(N_MAX);

    // Encode a one-hot vector into its bit index (zero when no bit is set)
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_MAX-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nto1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first
//                requesting channel found searching upward from ptr and
//                wrapping modulo N. Produces a one-hot grant and its index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;
    int               w_pos;

    // Rotating priority search: first request at or above ptr wins
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = int'(ptr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = SEL_W'(w_pos);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    // Index of the granted channel (meaningful only when some grant is set)
    always_comb begin
        gnt_idx = SEL_W'(onehot_to_idx(N_MAX'(gnt)));
    end

endmodule
`default_nettype wire

// File: rtl/mux_nto1_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nto1_rr
//  Description : Parametrised N:1 multiplexer with per-channel valid/ready
//                handshakes and a single registered output stage. mode=0
//                selects channel s directly; mode=1 arbitrates round-robin
//                among valid channels. Full throughput, one-cycle latency.
//                Optional feature macro: MUX_NTO1_PARITY_EN adds output y_par,
//                the even-parity bit of the word held in y.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] s,
    input  logic [N*W-1:0]   d,
    input  logic [N-1:0]     d_valid,
    output logic [N-1:0]     d_ready,
    output logic [W-1:0]     y,
    output logic             y_valid,
    input  logic             y_ready,
`ifdef MUX_NTO1_PARITY_EN
    output logic             y_par,
`endif
    output logic [SEL_W-1:0] y_sel
);

    logic [SEL_W-1:0] r_ptr;
    logic [W-1:0]     r_y;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_y_sel;
`ifdef MUX_NTO1_PARITY_EN
    logic             r_y_par;
`endif

    logic             w_rr_mode;
    logic [N-1:0]     w_rr_gnt;
    logic [SEL_W-1:0] w_rr_idx;
    logic [N-1:0]     w_sel_gnt;
    logic [N-1:0]     w_gnt;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_load_en;
    logic             w_xfer;
    logic [W-1:0]     w_din;
    logic [SEL_W-1:0] w_ptr_next;

    assign w_rr_mode = (mux_mode_t'(mode) == MODE_RR);

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (d_valid),
        .ptr     (r_ptr),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx)
    );

    // Direct select: grant channel s only when it is in range and valid
    always_comb begin
        w_sel_gnt = '0;
        if (int'(s) < N) begin
            w_sel_gnt[s] = d_valid[s];
        end
    end

    // Mode mux and ready gating; ready is held low during reset
    always_comb begin
        w_gnt     = w_rr_mode ? w_rr_gnt : w_sel_gnt;
        w_gnt_idx = w_rr_mode ? w_rr_idx : s;
        w_load_en = !r_y_valid || y_ready;
        d_ready   = rst ? '0 : (w_gnt & {N{w_load_en}});
        w_xfer    = |d_ready;
    end

    // One-hot AND-OR data select keeps out-of-range indices harmless
    always_comb begin
        w_din = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt[k]) begin
                w_din = w_din | d[k*W +: W];
            end
        end
    end

    // Pointer moves just past the channel that was served
    always_comb begin
        w_ptr_next = (w_gnt_idx == SEL_W'(N - 1)) ? '0 : (w_gnt_idx + 1'b1);
    end

    // Output stage: load on transfer, drain when consumed without a new word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_sel   <= '0;
`ifdef MUX_NTO1_PARITY_EN
            r_y_par   <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_y       <= w_din;
            r_y_sel   <= w_gnt_idx;
            r_y_valid <= 1'b1;
`ifdef MUX_NTO1_PARITY_EN
            r_y_par   <= ^w_din;
`endif
        end else if (y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances only on transfers made in RR mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer && w_rr_mode) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign y_sel   = r_y_sel;
`ifdef MUX_NTO1_PARITY_EN
    assign y_par   = r_y_par;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_nto1_rr
//  Description : Directed self-checking bench for mux_nto1_rr (N=8 and N=6
//                instances). Parity checks are active when MUX_NTO1_PARITY_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        yr = 1'b0;

    // N=8 instance
    logic [2:0]  s = '0;
    logic [63:0] d = '0;
    logic [7:0]  dv = '0;
    logic [7:0]  drdy;
    logic [7:0]  y;
    logic        yv;
    logic [2:0]  ysel;
`ifdef MUX_NTO1_PARITY_EN
    logic        ypar;
    logic        ypar6;
`endif

    // N=6 instance
    logic [2:0]  s6 = '0;
    logic [47:0] d6 = '0;
    logic [5:0]  dv6 = '0;
    logic [5:0]  drdy6;
    logic [7:0]  y6;
    logic        yv6;
    logic [2:0]  ysel6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_nto1_rr #(.N(8), .W(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .s       (s),
        .d       (d),
        .d_valid (dv),
        .d_ready (drdy),
        .y       (y),
        .y_valid (yv),
        .y_ready (yr),
`ifdef MUX_NTO1_PARITY_EN
        .y_par   (ypar),
`endif
        .y_sel   (ysel)
    );

    mux_nto1_rr #(.N(6), .W(8)) dut6 (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .s       (s6),
        .d       (d6),
        .d_valid (dv6),
        .d_ready (drdy6),
        .y       (y6),
        .y_valid (yv6),
        .y_ready (yr),
`ifdef MUX_NTO1_PARITY_EN
        .y_par   (ypar6),
`endif
        .y_sel   (ysel6)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Channel payloads on the N=8 instance
    function automatic logic [7:0] chdata(input int k);
        return (k == 5) ? 8'hA5 : 8'(8'h10 + k);
    endfunction

    int rr_seq [6] = '{0, 2, 5, 7, 0, 2};

    initial begin
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = chdata(k);
        for (int k = 0; k < 6; k++) d6[k*8 +: 8] = 8'(8'h60 + k);

        // Reset with a fully valid request pattern present
        mode = 1'b0; s = 3'd5; dv = 8'hFF; yr = 1'b1;
        #2 rst = 1'b1;
        #2;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_yv", 32'(yv), 32'h0);
        chk("rst_ysel", 32'(ysel), 32'h0);
        chk("rst_drdy", 32'(drdy), 32'h0);
        step();
        step();
        rst = 1'b0;

        // Direct select of channel 5
        #1 chk("sel_drdy0", 32'(drdy), 32'h20);
        step();
        chk("sel_y", 32'(y), 32'hA5);
        chk("sel_ysel", 32'(ysel), 32'd5);
        chk("sel_yv", 32'(yv), 32'h1);
        chk("sel_drdy1", 32'(drdy), 32'h20);
        step();
        chk("sel_y2", 32'(y), 32'hA5);
        chk("sel_drdy2", 32'(drdy), 32'h20);

        // Round-robin over channels 0,2,5,7 starting at pointer 0
        mode = 1'b1; dv = 8'b1010_0101;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rr_ysel%0d", i), 32'(ysel), 32'(rr_seq[i]));
            chk($sformatf("rr_yv%0d", i), 32'(yv), 32'h1);
            chk($sformatf("rr_y%0d", i), 32'(y), 32'(chdata(rr_seq[i])));
        end

        // Backpressure while holding channel 2; pointer is now 3
        yr = 1'b0;
        #1 chk("bp_drdy_now", 32'(drdy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bp_ysel%0d", i), 32'(ysel), 32'd2);
            chk($sformatf("bp_y%0d", i), 32'(y), 32'h12);
            chk($sformatf("bp_yv%0d", i), 32'(yv), 32'h1);
            chk($sformatf("bp_drdy%0d", i), 32'(drdy), 32'h0);
        end
        yr = 1'b1;
        #1 chk("bp_rel_drdy", 32'(drdy), 32'h20);
        step();
        chk("bp_rel_ysel", 32'(ysel), 32'd5);
        chk("bp_rel_y", 32'(y), 32'hA5);

        // Drain: no requests, consumer ready; y and y_sel hold
        dv = 8'h00;
        step();
        chk("drain_yv", 32'(yv), 32'h0);
        chk("drain_ysel", 32'(ysel), 32'd5);
        chk("drain_y", 32'(y), 32'hA5);

        // RR grant of ch3 from pointer 6 (wraps), leaving pointer 4
        dv = 8'h08;
        #1 chk("m_drdy_ch3", 32'(drdy), 32'h08);
        step();
        chk("m_ysel_ch3", 32'(ysel), 32'd3);
        // Direct select of ch1 in the same cycle as the mode change
        mode = 1'b0; s = 3'd1; dv = 8'h1A;
        #1 chk("m_drdy_ch1", 32'(drdy), 32'h02);
        step();
        chk("m_ysel_ch1", 32'(ysel), 32'd1);
        chk("m_y_ch1", 32'(y), 32'h11);
        // Back to RR: search resumes at 4, not after ch1
        mode = 1'b1;
        #1 chk("m_drdy_ch4", 32'(drdy), 32'h10);
        step();
        chk("m_ysel_ch4", 32'(ysel), 32'd4);
        chk("m_yv_ch4", 32'(yv), 32'h1);

        // Asynchronous reset while FULL, checked before any clock edge
        rst = 1'b1;
        #1;
        chk("ar_y", 32'(y), 32'h0);
        chk("ar_yv", 32'(yv), 32'h0);
        chk("ar_drdy", 32'(drdy), 32'h0);
        step();
        rst = 1'b0;
        dv = 8'h81;
        #1 chk("ar_first_drdy", 32'(drdy), 32'h01);
        step();
        chk("ar_first_ysel", 32'(ysel), 32'd0);
        chk("ar_first_y", 32'(y), 32'h10);

        // N=6: out-of-range selects never grant
        mode = 1'b0; dv = 8'h00; s6 = 3'd7; dv6 = 6'h3F;
        #1 chk("n6_s7_drdy", 32'(drdy6), 32'h0);
        step();
        chk("n6_s7_yv", 32'(yv6), 32'h0);
        chk("n6_s7_y", 32'(y6), 32'h0);
        s6 = 3'd4;
        #1 chk("n6_s4_drdy", 32'(drdy6), 32'h10);
        step();
        chk("n6_s4_y", 32'(y6), 32'h64);
        chk("n6_s4_ysel", 32'(ysel6), 32'd4);
        chk("n6_s4_yv", 32'(yv6), 32'h1);
        s6 = 3'd6;
        #1 chk("n6_s6_drdy", 32'(drdy6), 32'h0);
        step();
        chk("n6_s6_yv", 32'(yv6), 32'h0);
        dv6 = '0;

`ifdef MUX_NTO1_PARITY_EN
        // Even parity of the loaded word
        mode = 1'b0; s = 3'd0; dv = 8'h01; d[7:0] = 8'h07;
        step();
        chk("par_y07", 32'(y), 32'h07);
        chk("par_07", 32'(ypar), 32'h1);
        d[7:0] = 8'h03;
        step();
        chk("par_y03", 32'(y), 32'h03);
        chk("par_03", 32'(ypar), 32'h0);
        dv = 8'h00;
        step();
        chk("par_hold", 32'(ypar), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
